// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall hold buffer, flush bubbles,
// a post-reset wait cycle, and saturating stall/flush event counters.
module if_id_register #(
  parameter logic [31:0] NOP   = 32'h00000000,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [9:0]       PC,
  input  logic [9:0]       PCPlus1,
  input  logic [31:0]      instruction,
  output logic [9:0]       ID_PC,
  output logic [9:0]       ID_PCPlus1,
  output logic [31:0]      ID_instruction,
  output logic             ID_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {WAIT, RUN, HOLD} state_t;

  state_t state, state_nxt;

  logic [9:0]       hold_pc, hold_pcp1;
  logic [31:0]      hold_instr;

  logic [9:0]       pc_nxt, pcp1_nxt;
  logic [31:0]      instr_nxt;
  logic             valid_nxt;
  logic [9:0]       hold_pc_nxt, hold_pcp1_nxt;
  logic [31:0]      hold_instr_nxt;
  logic [CNT_W-1:0] stall_cnt_nxt, flush_cnt_nxt;

  // State register; reset always returns to the memory-latency wait state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT;
    else      state <= state_nxt;
  end

  // Next-state logic: flush wins over stall and always lands in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:    state_nxt = RUN;
      RUN:     state_nxt = (!flush && stall) ? HOLD : RUN;
      HOLD:    state_nxt = (flush || !stall) ? RUN : HOLD;
      default: state_nxt = WAIT;
    endcase
  end

  // Next values for the decode-side registers, hold buffer and counters.
  always_comb begin
    pc_nxt         = ID_PC;
    pcp1_nxt       = ID_PCPlus1;
    instr_nxt      = ID_instruction;
    valid_nxt      = ID_valid;
    hold_pc_nxt    = hold_pc;
    hold_pcp1_nxt  = hold_pcp1;
    hold_instr_nxt = hold_instr;
    stall_cnt_nxt  = stall_count;
    flush_cnt_nxt  = flush_count;
    if (state != WAIT) begin
      if (stall && (stall_count != '1)) stall_cnt_nxt = stall_count + CNT_ONE;
      if (flush && (flush_count != '1)) flush_cnt_nxt = flush_count + CNT_ONE;
      if (flush) begin
        pc_nxt    = '0;
        pcp1_nxt  = '0;
        instr_nxt = NOP;
        valid_nxt = 1'b0;
      end else if (!stall) begin
        // Leaving HOLD replays the captured fetch; live inputs are re-presented later.
        if (state == HOLD) begin
          pc_nxt    = hold_pc;
          pcp1_nxt  = hold_pcp1;
          instr_nxt = hold_instr;
        end else begin
          pc_nxt    = PC;
          pcp1_nxt  = PCPlus1;
          instr_nxt = instruction;
        end
        valid_nxt = 1'b1;
      end else if (state == RUN) begin
        hold_pc_nxt    = PC;
        hold_pcp1_nxt  = PCPlus1;
        hold_instr_nxt = instruction;
      end
    end
  end

  // Output, hold-buffer and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ID_PC          <= '0;
      ID_PCPlus1     <= '0;
      ID_instruction <= NOP;
      ID_valid       <= 1'b0;
      hold_pc        <= '0;
      hold_pcp1      <= '0;
      hold_instr     <= '0;
      stall_count    <= '0;
      flush_count    <= '0;
    end else begin
      ID_PC          <= pc_nxt;
      ID_PCPlus1     <= pcp1_nxt;
      ID_instruction <= instr_nxt;
      ID_valid       <= valid_nxt;
      hold_pc        <= hold_pc_nxt;
      hold_pcp1      <= hold_pcp1_nxt;
      hold_instr     <= hold_instr_nxt;
      stall_count    <= stall_cnt_nxt;
      flush_count    <= flush_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_if_id_register.sv
// Self-checking bench for if_id_register: directed vector table,
// randomized run against a transaction-level model, reset-mid-HOLD
// and counter saturation sequences.
module tb_if_id_register;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;
  localparam int          CMAX   = 65535;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [9:0]  pc, pcp1;
  logic [31:0] ins;
  logic [9:0]  id_pc, id_pcp1;
  logic [31:0] id_ins;
  logic        id_valid;
  logic [15:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  if_id_register #(.NOP(TB_NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .PC(pc), .PCPlus1(pcp1), .instruction(ins),
    .ID_PC(id_pc), .ID_PCPlus1(id_pcp1), .ID_instruction(id_ins),
    .ID_valid(id_valid), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [9:0] epc, input logic [9:0] epcp1,
                         input logic [31:0] eins, input logic ev);
    chk({tag, ".ID_PC"}, 64'(id_pc), 64'(epc));
    chk({tag, ".ID_PCPlus1"}, 64'(id_pcp1), 64'(epcp1));
    chk({tag, ".ID_instruction"}, 64'(id_ins), 64'(eins));
    chk({tag, ".ID_valid"}, 64'(id_valid), 64'(ev));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: a fetch is either delivered, parked, or squashed.
  typedef struct {
    logic [9:0]  pc;
    logic [9:0]  pcp1;
    logic [31:0] ins;
  } fetch_t;

  fetch_t      parked[$];
  bit          m_first;
  logic [9:0]  m_pc, m_pcp1;
  logic [31:0] m_ins;
  logic        m_valid;
  int          m_sc, m_fc;

  task automatic model_reset();
    parked.delete();
    m_first = 1'b1;
    m_pc = '0; m_pcp1 = '0; m_ins = TB_NOP; m_valid = 1'b0;
    m_sc = 0; m_fc = 0;
  endtask

  task automatic model_edge();
    fetch_t f;
    if (m_first) begin
      m_first = 1'b0;
      return;
    end
    if (stall && m_sc < CMAX) m_sc++;
    if (flush && m_fc < CMAX) m_fc++;
    if (flush) begin
      parked.delete();
      m_pc = '0; m_pcp1 = '0; m_ins = TB_NOP; m_valid = 1'b0;
    end else if (stall) begin
      if (parked.size() == 0) parked.push_back('{pc, pcp1, ins});
    end else begin
      if (parked.size() != 0) f = parked.pop_front();
      else                    f = '{pc, pcp1, ins};
      m_pc = f.pc; m_pcp1 = f.pcp1; m_ins = f.ins; m_valid = 1'b1;
    end
  endtask

  typedef struct {
    logic        s, f;
    logic [9:0]  pc, pcp1;
    logic [31:0] ins;
    logic [9:0]  epc, epcp1;
    logic [31:0] eins;
    logic        ev;
    int          esc, efc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; pc = '0; pcp1 = '0; ins = '0;
    #12;
    chk_out("reset", 10'h000, 10'h000, TB_NOP, 1'b0);
    chk("reset.stall_count", 64'(stall_count), 64'd0);
    chk("reset.flush_count", 64'(flush_count), 64'd0);

    //          s  f  pc      pcp1    ins            epc     epcp1   eins           ev  sc fc
    tbl[0]  = '{0, 0, 10'd5,  10'd6,  32'h12345678, 10'd0,  10'd0,  TB_NOP,       0, 0, 0};
    tbl[1]  = '{0, 0, 10'd5,  10'd6,  32'h12345678, 10'd5,  10'd6,  32'h12345678, 1, 0, 0};
    tbl[2]  = '{0, 0, 10'd7,  10'd8,  32'h00000077, 10'd7,  10'd8,  32'h00000077, 1, 0, 0};
    tbl[3]  = '{1, 0, 10'd8,  10'd9,  32'hAAAA0001, 10'd7,  10'd8,  32'h00000077, 1, 1, 0};
    tbl[4]  = '{1, 0, 10'h155,10'h2AA,32'hDEADBEEF, 10'd7,  10'd8,  32'h00000077, 1, 2, 0};
    tbl[5]  = '{1, 0, 10'h0F0,10'h00F,32'hBADBAD00, 10'd7,  10'd8,  32'h00000077, 1, 3, 0};
    tbl[6]  = '{0, 0, 10'h0F1,10'h0F2,32'h0BADF00D, 10'd8,  10'd9,  32'hAAAA0001, 1, 3, 0};
    tbl[7]  = '{0, 0, 10'h3FF,10'h000,32'h0000CAFE, 10'h3FF,10'h000,32'h0000CAFE, 1, 3, 0};
    tbl[8]  = '{1, 1, 10'd12, 10'd13, 32'h11111111, 10'd0,  10'd0,  TB_NOP,       0, 4, 1};
    tbl[9]  = '{0, 0, 10'd16, 10'd17, 32'h00001010, 10'd16, 10'd17, 32'h00001010, 1, 4, 1};
    tbl[10] = '{1, 0, 10'd32, 10'd33, 32'h00002020, 10'd16, 10'd17, 32'h00001010, 1, 5, 1};
    tbl[11] = '{1, 1, 10'd48, 10'd49, 32'h00003030, 10'd0,  10'd0,  TB_NOP,       0, 6, 2};
    tbl[12] = '{0, 0, 10'd64, 10'd65, 32'h00004040, 10'd64, 10'd65, 32'h00004040, 1, 6, 2};

    rst = 1'b1;
    for (int i = 0; i < 13; i++) begin
      stall = tbl[i].s; flush = tbl[i].f;
      pc = tbl[i].pc; pcp1 = tbl[i].pcp1; ins = tbl[i].ins;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].epc, tbl[i].epcp1, tbl[i].eins, tbl[i].ev);
      chk($sformatf("vec%0d.stall_count", i), 64'(stall_count), 64'(tbl[i].esc));
      chk($sformatf("vec%0d.flush_count", i), 64'(flush_count), 64'(tbl[i].efc));
    end

    // Randomized run with occasional mid-cycle resets.
    rst = 1'b0; #2; rst = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(0, 99) < 40);
      flush = ($urandom_range(0, 99) < 15);
      pc    = 10'($urandom); pcp1 = pc + 10'd1; ins = $urandom;
      model_edge();
      step();
      chk_out("rand", m_pc, m_pcp1, m_ins, m_valid);
      chk("rand.stall_count", 64'(stall_count), 64'(m_sc));
      chk("rand.flush_count", 64'(flush_count), 64'(m_fc));
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
      end
    end

    // Reset asserted between edges while in HOLD.
    rst = 1'b0; #2; rst = 1'b1;
    stall = 1'b0; flush = 1'b0;
    pc = 10'd100; pcp1 = 10'd101; ins = 32'h0000_0100;
    step();                      // WAIT
    step();                      // RUN loads 100
    chk_out("midrst.pre", 10'd100, 10'd101, 32'h0000_0100, 1'b1);
    stall = 1'b1; pc = 10'd200; pcp1 = 10'd201; ins = 32'h0000_0200;
    step();                      // enter HOLD, park 200
    rst = 1'b0;
    #2;
    chk_out("midrst.async", 10'd0, 10'd0, TB_NOP, 1'b0);
    chk("midrst.stall_count", 64'(stall_count), 64'd0);
    rst = 1'b1;
    stall = 1'b0; pc = 10'd300; pcp1 = 10'd301; ins = 32'h0000_0300;
    step();
    chk_out("midrst.wait", 10'd0, 10'd0, TB_NOP, 1'b0);
    step();
    chk_out("midrst.run", 10'd300, 10'd301, 32'h0000_0300, 1'b1);

    // Stall counter saturation.
    stall = 1'b1;
    for (int n = 0; n < 65534; n++) step();
    chk("sat.below", 64'(stall_count), 64'h0000_FFFE);
    step();
    chk("sat.reach", 64'(stall_count), 64'h0000_FFFF);
    for (int n = 0; n < 6; n++) step();
    chk("sat.hold", 64'(stall_count), 64'h0000_FFFF);
    chk("sat.flush_count", 64'(flush_count), 64'd0);
    chk_out("sat.frozen", 10'd300, 10'd301, 32'h0000_0300, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
IF_ID_REGISTER -- requirements
Module: if_id_register

Interface
REQ-001 The block SHALL have parameter NOP, default 32'h00000000, which is the instruction word inserted for bubbles.
REQ-002 The block SHALL have parameter CNT_W, default 16, which is the width of the stall and flush event counters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-005 The block SHALL have port stall, input, 1 bit: when 1, freezes the decode-side outputs.
REQ-006 The block SHALL have port flush, input, 1 bit: when 1, squashes the instruction entering decode (taken branch, jump or jr).
REQ-007 The block SHALL have port PC, input, 10 bits: the fetch-stage program counter.
REQ-008 The block SHALL have port PCPlus1, input, 10 bits: the fetch-stage PC + 1.
REQ-009 The block SHALL have port instruction, input, 32 bits: the synchronous instruction-memory output, aligned with PC.
REQ-010 The block SHALL have port ID_PC, output, 10 bits: the decode-stage PC.
REQ-011 The block SHALL have port ID_PCPlus1, output, 10 bits: the decode-stage PC + 1.
REQ-012 The block SHALL have port ID_instruction, output, 32 bits: the decode-stage instruction.
REQ-013 The block SHALL have port ID_valid, output, 1 bit: 1 when ID_instruction is a real (non-bubble) instruction.
REQ-014 The block SHALL have port stall_count, output, CNT_W bits: a saturating count of stall cycles.
REQ-015 The block SHALL have port flush_count, output, CNT_W bits: a saturating count of flush cycles.

Function
REQ-016 All outputs SHALL be registered, with a latency of one clock from the inputs to the ID_* outputs.
REQ-017 The FSM SHALL have three states: WAIT (entered by reset), RUN and HOLD.
REQ-018 In WAIT, the outputs SHALL keep their reset values, stall and flush SHALL be ignored, the counters SHALL not change, and the next state SHALL be RUN (this covers the one-cycle memory read latency after reset).
REQ-019 In RUN with flush=1, the block SHALL load ID_instruction<=NOP, ID_valid<=0, ID_PC<=0 and ID_PCPlus1<=0, and SHALL stay in RUN.
REQ-020 In RUN with flush=0 and stall=0, the block SHALL load ID_* from the inputs with ID_valid<=1, and SHALL stay in RUN.
REQ-021 In RUN with flush=0 and stall=1, the block SHALL hold the ID_* outputs, capture {PC, PCPlus1, instruction} into a hold buffer, and go to HOLD.
REQ-022 In HOLD with flush=0 and stall=1, the ID_* outputs and the hold buffer SHALL remain unchanged, and all inputs SHALL be ignored.
REQ-023 In HOLD with flush=0 and stall=0, the block SHALL load ID_* from the hold buffer with ID_valid<=1, SHALL discard the inputs on that edge (upstream re-presents them), and SHALL go to RUN.
REQ-024 In HOLD with flush=1, the block SHALL insert a bubble as in REQ-019, discard the hold buffer, and go to RUN.
REQ-025 When flush and stall are both 1, flush SHALL take priority.
REQ-026 stall_count SHALL increment on every edge where stall=1 in RUN or HOLD, including cycles where flush=1 also.
REQ-027 flush_count SHALL increment on every edge where flush=1 in RUN or HOLD.
REQ-028 Both counters SHALL saturate at all-ones and SHALL never wrap.
REQ-029 ID_PCPlus1 SHALL be passed through unmodified and never recomputed; 10-bit values SHALL wrap naturally (PC=10'h3FF gives PCPlus1=10'h000 upstream, and the block passes it unchanged).

Reset
REQ-030 While rst=0, the block SHALL immediately and asynchronously force state=WAIT, ID_instruction=NOP, ID_valid=0, ID_PC=0, ID_PCPlus1=0, hold buffer=0, stall_count=0 and flush_count=0.
REQ-031 Reset asserted mid-HOLD or mid-flush SHALL discard all captured state, with no partial update on the deassertion edge.
REQ-032 The first rising edge after rst goes to 1 SHALL be spent in WAIT (REQ-018).

Verification
REQ-033 Scenario (reset): release rst, then present PC=5, PCPlus1=6, instruction=32'h12345678 -> the first edge stays in WAIT with ID_valid=0; the second edge gives ID_PC=5, ID_PCPlus1=6, ID_instruction=32'h12345678, ID_valid=1.
REQ-034 Scenario (stall): in RUN, stall=1 for 3 cycles while the input is PC=8 with instruction=32'hAAAA0001 and the input then changes to garbage -> ID_* stay frozen for 3 cycles; on release ID_PC=8 and ID_instruction=32'hAAAA0001; stall_count=3.
REQ-035 Scenario (priority): flush=1 and stall=1 on the same edge in RUN -> ID_instruction=NOP, ID_valid=0, state RUN, stall_count+1, flush_count+1.
REQ-036 Scenario (flush in HOLD): flush=1 during HOLD -> a bubble is output, the hold buffer contents never appear on ID_*, and the next non-stalled edge loads the live inputs.
REQ-037 Scenario (counters): force stall=1 for 2^CNT_W+5 cycles -> stall_count holds at 16'hFFFF.
REQ-038 Scenario (reset mid-op): assert rst=0 asynchronously between edges during HOLD -> all outputs reach their reset values before the next edge, and the WAIT cycle recurs after release.
